regfifo_param: RTL and testbench

//  Parametrised register-based shift FIFO; successor to the fixed 48b x 8 reg FIFO used in the DMA path.

---
 rtl/regfifo_param_if.sv | 31 +++
 rtl/regfifo_param.sv | 99 +++++++++
 tb/tb_regfifo_param.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/regfifo_param_if.sv
// Handshake and status bundle for regfifo_param. The master modport drives writes, reads and flush.
// The slave modport returns head data, occupancy, thresholds and error pulses.
interface regfifo_param_if #(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/regfifo_param.sv
// Register shift FIFO with the head always in slot 0 (first-word-fall-through), so dout needs no read latency.
// Write-to-dout and read-to-next-head both take 1 cycle. There is no backpressure: a write while full is dropped, and a read while empty is ignored, each raising a 1-cycle pulse.
module regfifo_param #(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 8,
    parameter int AFULL_THR  = DEPTH - 1,
    parameter int AEMPTY_THR = 1
) (
    input  logic           clk,
    input  logic           srst,
    regfifo_param_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] slot_q [DEPTH];
    logic [DATA_WIDTH-1:0] slot_d [DEPTH];
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      wr_idx;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  unf_q;
    logic                  unf_d;
    logic                  is_full;
    logic                  is_empty;
    logic                  do_rd;
    logic                  do_wr;

    assign is_full  = (cnt_q == CNT_W'(DEPTH));
    assign is_empty = (cnt_q == '0);

    always_comb begin
        do_rd  = bus.rd_en && !is_empty;
        // A simultaneous read frees a slot, so a write is still accepted when full.
        do_wr  = bus.wr_en && (!is_full || do_rd);
        wr_idx = do_rd ? (cnt_q - CNT_W'(1)) : cnt_q;

        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = '0;
            end
            cnt_d = '0;
        end else begin
            if (do_rd) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slot_d[i] = slot_q[i + 1];
                end
                slot_d[DEPTH-1] = '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_wr && (wr_idx == CNT_W'(i))) begin
                    slot_d[i] = bus.din;
                end
            end
            if (do_wr && !do_rd) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            ovf_d = bus.wr_en && !do_wr;
            unf_d = bus.rd_en && is_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Unused slots are held at zero, so an empty FIFO shows zero on dout.
    assign bus.dout         = slot_q[0];
    assign bus.count        = cnt_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (cnt_q >= CNT_W'(AFULL_THR));
    assign bus.almost_empty = (cnt_q <= CNT_W'(AEMPTY_THR));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_regfifo_param.sv
// Bench for regfifo_param: a queue model checked on every cycle for two configurations, with directed literal checks and a randomized phase.
module tb_regfifo_param;
    localparam int WA = 48, DA = 8, AFA = 7, AEA = 1;
    localparam int WB = 16, DB = 2, AFB = 2, AEB = 1;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    regfifo_param_if #(.DATA_WIDTH(WA), .DEPTH(DA)) bus_a ();
    regfifo_param_if #(.DATA_WIDTH(WB), .DEPTH(DB)) bus_b ();

    regfifo_param #(.DATA_WIDTH(WA), .DEPTH(DA), .AFULL_THR(AFA), .AEMPTY_THR(AEA)) dut_a (
        .clk(clk), .srst(srst), .bus(bus_a)
    );
    regfifo_param #(.DATA_WIDTH(WB), .DEPTH(DB), .AFULL_THR(AFB), .AEMPTY_THR(AEB)) dut_b (
        .clk(clk), .srst(srst), .bus(bus_b)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    logic [WA-1:0] qa[$];
    logic [WB-1:0] qb[$];
    bit ov_a, uf_a, ov_b, uf_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue updated by the rules srst > flush > read/write.
    always @(posedge clk) begin
        if (srst || bus_a.flush) begin
            qa.delete(); ov_a = 0; uf_a = 0;
        end else begin
            uf_a = bus_a.rd_en && qa.size() == 0;
            ov_a = bus_a.wr_en && !bus_a.rd_en && qa.size() == DA;
            if (bus_a.rd_en && qa.size() != 0) void'(qa.pop_front());
            if (bus_a.wr_en && qa.size() < DA) qa.push_back(bus_a.din);
        end
        if (srst || bus_b.flush) begin
            qb.delete(); ov_b = 0; uf_b = 0;
        end else begin
            uf_b = bus_b.rd_en && qb.size() == 0;
            ov_b = bus_b.wr_en && !bus_b.rd_en && qb.size() == DB;
            if (bus_b.rd_en && qb.size() != 0) void'(qb.pop_front());
            if (bus_b.wr_en && qb.size() < DB) qb.push_back(bus_b.din);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_dout",  64'(bus_a.dout), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
            chk("a_count", 64'(bus_a.count), 64'(qa.size()));
            chk("a_full",  64'(bus_a.full),  64'(qa.size() == DA));
            chk("a_empty", 64'(bus_a.empty), 64'(qa.size() == 0));
            chk("a_afull", 64'(bus_a.almost_full),  64'(qa.size() >= AFA));
            chk("a_aempty",64'(bus_a.almost_empty), 64'(qa.size() <= AEA));
            chk("a_ovf",   64'(bus_a.overflow),  64'(ov_a));
            chk("a_unf",   64'(bus_a.underflow), 64'(uf_a));
            chk("b_dout",  64'(bus_b.dout), (qb.size() != 0) ? 64'(qb[0]) : 64'd0);
            chk("b_count", 64'(bus_b.count), 64'(qb.size()));
            chk("b_full",  64'(bus_b.full),  64'(qb.size() == DB));
            chk("b_empty", 64'(bus_b.empty), 64'(qb.size() == 0));
            chk("b_afull", 64'(bus_b.almost_full),  64'(qb.size() >= AFB));
            chk("b_aempty",64'(bus_b.almost_empty), 64'(qb.size() <= AEB));
            chk("b_ovf",   64'(bus_b.overflow),  64'(ov_b));
            chk("b_unf",   64'(bus_b.underflow), 64'(uf_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_a(input logic wr, input logic rd, input logic fl, input logic [WA-1:0] d);
        bus_a.wr_en = wr; bus_a.rd_en = rd; bus_a.flush = fl; bus_a.din = d;
        cyc();
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.flush = 0;
    endtask

    task automatic step_b(input logic wr, input logic rd, input logic [WB-1:0] d);
        bus_b.wr_en = wr; bus_b.rd_en = rd; bus_b.din = d;
        cyc();
        bus_b.wr_en = 0; bus_b.rd_en = 0;
    endtask

    initial begin
        srst = 1;
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.flush = 0; bus_a.din = '0;
        bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.flush = 0; bus_b.din = '0;
        cyc(); cyc();
        chk_en = 1;
        srst = 0;

        // Reset values
        chk("rst_count", 64'(bus_a.count), 64'd0);
        chk("rst_empty", 64'(bus_a.empty), 64'd1);
        chk("rst_aempty", 64'(bus_a.almost_empty), 64'd1);
        chk("rst_dout", 64'(bus_a.dout), 64'd0);

        // Fill 1..8; almost_full from count 7
        for (int i = 1; i <= 8; i++) begin
            step_a(1, 0, 0, WA'(i));
            if (i == 6) chk("afull_at6", 64'(bus_a.almost_full), 64'd0);
            if (i == 7) chk("afull_at7", 64'(bus_a.almost_full), 64'd1);
        end
        chk("fill_count", 64'(bus_a.count), 64'd8);
        chk("fill_full", 64'(bus_a.full), 64'd1);
        chk("fill_dout", 64'(bus_a.dout), 64'd1);

        // Overflow while full, then drain in order
        step_a(1, 0, 0, WA'(9));
        chk("ovf_pulse", 64'(bus_a.overflow), 64'd1);
        chk("ovf_count", 64'(bus_a.count), 64'd8);
        cyc();
        chk("ovf_clear", 64'(bus_a.overflow), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_dout", 64'(bus_a.dout), 64'(i));
            step_a(0, 1, 0, '0);
        end
        chk("drain_empty", 64'(bus_a.empty), 64'd1);
        chk("drain_dout0", 64'(bus_a.dout), 64'd0);

        // Simultaneous wr&rd at count 3
        step_a(1, 0, 0, 48'h11); step_a(1, 0, 0, 48'h22); step_a(1, 0, 0, 48'h33);
        step_a(1, 1, 0, 48'hA);
        chk("wrrd_count", 64'(bus_a.count), 64'd3);
        chk("wrrd_h0", 64'(bus_a.dout), 64'h22); step_a(0, 1, 0, '0);
        chk("wrrd_h1", 64'(bus_a.dout), 64'h33); step_a(0, 1, 0, '0);
        chk("wrrd_h2", 64'(bus_a.dout), 64'hA);  step_a(0, 1, 0, '0);

        // wr&rd on empty, then read-only on empty
        step_a(1, 1, 0, 48'h5);
        chk("erw_unf", 64'(bus_a.underflow), 64'd1);
        chk("erw_count", 64'(bus_a.count), 64'd1);
        chk("erw_dout", 64'(bus_a.dout), 64'h5);
        step_a(0, 1, 0, '0);
        step_a(0, 1, 0, '0);
        chk("er_unf", 64'(bus_a.underflow), 64'd1);
        chk("er_count", 64'(bus_a.count), 64'd0);

        // Flush with write at count 5, then srst mid-stream
        for (int i = 0; i < 5; i++) step_a(1, 0, 0, WA'(i + 40));
        step_a(1, 0, 1, 48'h77);
        chk("fl_count", 64'(bus_a.count), 64'd0);
        chk("fl_dout", 64'(bus_a.dout), 64'd0);
        chk("fl_ovf", 64'(bus_a.overflow), 64'd0);
        for (int i = 0; i < 3; i++) step_a(1, 0, 0, WA'(i + 60));
        srst = 1;
        step_a(1, 1, 0, 48'h99);
        srst = 0;
        chk("sr_count", 64'(bus_a.count), 64'd0);
        chk("sr_dout", 64'(bus_a.dout), 64'd0);
        chk("sr_unf", 64'(bus_a.underflow), 64'd0);

        // DEPTH=2 boundaries
        step_b(1, 0, 16'hBEEF);
        chk("b1_count", 64'(bus_b.count), 64'd1);
        chk("b1_aempty", 64'(bus_b.almost_empty), 64'd1);
        chk("b1_afull", 64'(bus_b.almost_full), 64'd0);
        step_b(1, 0, 16'h1234);
        chk("b2_full", 64'(bus_b.full), 64'd1);
        chk("b2_afull", 64'(bus_b.almost_full), 64'd1);
        chk("b2_aempty", 64'(bus_b.almost_empty), 64'd0);
        step_b(1, 0, 16'h5555);
        chk("b3_ovf", 64'(bus_b.overflow), 64'd1);
        step_b(1, 1, 16'h6666);
        chk("b4_dout", 64'(bus_b.dout), 64'h1234);
        chk("b4_ovf", 64'(bus_b.overflow), 64'd0);
        step_b(0, 1, '0); step_b(0, 1, '0);
        chk("b5_empty", 64'(bus_b.empty), 64'd1);

        // Randomized phase with a fill/drain bias that changes every 100 cycles
        for (int n = 0; n < 3000; n++) begin
            int wr_pct;
            wr_pct = ((n / 100) % 2 == 0) ? 70 : 30;
            srst        = ($urandom_range(0, 299) == 0);
            bus_a.flush = ($urandom_range(0, 79) == 0);
            bus_b.flush = ($urandom_range(0, 79) == 0);
            bus_a.wr_en = ($urandom_range(0, 99) < wr_pct);
            bus_a.rd_en = ($urandom_range(0, 99) < 100 - wr_pct);
            bus_b.wr_en = ($urandom_range(0, 99) < wr_pct);
            bus_b.rd_en = ($urandom_range(0, 99) < 100 - wr_pct);
            bus_a.din   = WA'({$urandom, $urandom});
            bus_b.din   = WB'($urandom);
            cyc();
        end
        srst = 0;
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.flush = 0;
        bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.flush = 0;
        cyc();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
